shared_multi_fifo: RTL and testbench
====================================

# shared_multi_fifo

Next-generation shared-memory multi-FIFO: NUM_FIFOS logical FIFOs share one DEPTH-entry data store, managed by a free list plus per-FIFO linked lists of next-pointers. Unlike the prior single-operation version, it accepts a push and a pop in the same cycle, including when full via slot reuse. It registers read data with a valid strobe, exposes per-FIFO occupancy, and flags illegal requests instead of leaving them undefined. It sits between a multi-channel producer and consumer wherever per-channel buffering must share one memory.

## Interface
- WIDTH, 8, data width
- DEPTH, 8, shared entries; power of two, ≥2
- NUM_FIFOS, 4, logical FIFOs; ≥2
- PTR_WIDTH, $clog2(DEPTH), entry pointer width
- SEL_WIDTH, $clog2(NUM_FIFOS), FIFO select width
- CNT_WIDTH, $clog2(DEPTH+1), occupancy counter width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-low reset
- push  in  1  push request
- push_sel  in  SEL_WIDTH  target FIFO of push
- data_in  in  WIDTH  push data
- pop  in  1  pop request
- pop_sel  in  SEL_WIDTH  source FIFO of pop
- full  out  1  no free entries
- empty  out  NUM_FIFOS  bit i = FIFO i has zero entries
- count  out  NUM_FIFOS*CNT_WIDTH  occupancy of FIFO i in bits [i*CNT_WIDTH +: CNT_WIDTH]
- free_count  out  CNT_WIDTH  free entries
- data_out  out  WIDTH  registered pop data
- out_valid  out  1  data_out holds data from the previous cycle's accepted pop
- err_overflow  out  1  sticky: push rejected
- err_underflow  out  1  sticky: pop rejected

## Operation
- State: mem[DEPTH], nxt[DEPTH] pointer array, free_head/free_tail, per-FIFO head/tail/count, free_count.
- Reset (rst=0 at an edge): all counts 0, empty all ones, full 0, free_count DEPTH, free list chained 0→1→…→DEPTH-1, data_out 0, out_valid 0, both error flags 0. Reset mid-operation discards all contents; mem is not cleared.
- Pop accepted iff pop=1 and count[pop_sel]≠0. The accepted pop:
  - captures mem[head] into data_out;
  - advances head ← nxt[head] and decrements count;
  - appends the freed entry to the free list tail.
- Push accepted iff push=1 and (free_count≠0 or a pop is accepted in the same cycle). The accepted push:
  - allocates free_head, or the entry being freed by the same-cycle pop when free_count=0;
  - writes data_in, links it after the target tail (or sets head=tail when the FIFO is empty) and increments count.
- Simultaneous push and pop:
  - Different FIFOs: both proceed; free_count unchanged.
  - Same FIFO with count=0: pop rejected (no empty bypass), push proceeds.
  - Same FIFO with count=1: the old head is freed and the new entry becomes head and tail.
- Rejected push: nothing changes; err_overflow←1. Rejected pop: nothing changes; out_valid←0 and err_underflow←1. Flags clear only on reset.
- Invariant: sum(count)+free_count = DEPTH at every cycle.
- Out-of-range sel (≥NUM_FIFOS) counts as a rejected request of that type.

## Timing
- All outputs are registered. They reflect requests accepted at the previous edge.
- Pop latency is 1 cycle: data_out/out_valid are valid the cycle after an accepted pop. data_out holds its value when out_valid=0.
- Push-to-pop: an entry pushed at edge N is poppable by a request presented in cycle N+1 (pop accepted at edge N+1).
- Pop at edge N after a push of the same slot at edge N returns the new data only when that slot is the FIFO head; mem writes must be visible to the next-cycle read.
- No ready/valid stall: requests are evaluated against current registered state in the same cycle.

## Structure
- Package shared_multi_fifo_pkg holds the pointer/count width functions, the reset free-list init value (i+1 chaining), and the error-flag encoding.
- One sub-module, sml_ptr_ctrl, owns nxt, the free list, heads/tails, counts and accept logic. It outputs alloc_ptr, free_ptr, push_ok and pop_ok.
- Top level owns mem, data_out and out_valid.

## Test plan
- Reset then idle: full=0, empty=4'b1111, free_count=8, all counts 0, flags 0, out_valid 0.
- Push 0xA1,0xA2 to FIFO 2, then pop FIFO 2 twice: data_out 0xA1 then 0xA2 with out_valid=1 each cycle; empty[2] returns to 1.
- Fill 8 entries across FIFOs 0/1. A lone push is rejected: err_overflow=1, counts unchanged. Then push FIFO 3 (0x55) with pop FIFO 0 in the same cycle: both accepted, full stays 1, count[3]=1, and a later pop FIFO 3 returns 0x55.
- FIFO 1 count=1 (0x10): push 0x11 and pop FIFO 1 in the same cycle → data_out 0x10 next cycle, count[1]=1, next pop returns 0x11.
- Pop empty FIFO 0 → out_valid=0, err_underflow=1, free_count unchanged. A simultaneous push to FIFO 0 is still accepted.
- Assert rst=0 mid-stream with 5 entries stored → next cycle matches reset values. A push/pop after reset returns the new data, never stale contents.

Source files
------------

// File: rtl/shared_multi_fifo_pkg.sv
// Shared types, width helpers and constants for the shared-memory multi-FIFO.
// Imported by the pointer controller and the top level.
package shared_multi_fifo_pkg;

  localparam int ERR_W   = 2;
  localparam int ERR_OVF = 0;
  localparam int ERR_UNF = 1;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int sel_w(input int nf);
    return $clog2(nf);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Reset chain of the free list: entry i links to i+1.
  function automatic int free_init(input int i, input int depth);
    return (i + 1) % depth;
  endfunction

endpackage

// File: rtl/shared_multi_fifo_ptr_ctrl.sv
// Linked-list bookkeeping: free list, per-FIFO head/tail/count, accept logic.
// Supports one push and one pop per cycle, including slot reuse when full.
module sml_ptr_ctrl
  import shared_multi_fifo_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int NUM_FIFOS = 4,
  parameter int PTR_WIDTH = ptr_w(DEPTH),
  parameter int SEL_WIDTH = sel_w(NUM_FIFOS),
  parameter int CNT_WIDTH = cnt_w(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [SEL_WIDTH-1:0]           push_sel,
  input  logic                           pop,
  input  logic [SEL_WIDTH-1:0]           pop_sel,
  output logic [PTR_WIDTH-1:0]           alloc_ptr,
  output logic [PTR_WIDTH-1:0]           free_ptr,
  output logic                           push_ok,
  output logic                           pop_ok,
  output logic                           full,
  output logic [NUM_FIFOS-1:0]           empty,
  output logic [NUM_FIFOS*CNT_WIDTH-1:0] count,
  output logic [CNT_WIDTH-1:0]           free_count
);

  logic [PTR_WIDTH-1:0] nxt  [DEPTH];
  logic [PTR_WIDTH-1:0] head [NUM_FIFOS];
  logic [PTR_WIDTH-1:0] tail [NUM_FIFOS];
  logic [CNT_WIDTH-1:0] cnt  [NUM_FIFOS];
  logic [PTR_WIDTH-1:0] free_head;
  logic [PTR_WIDTH-1:0] free_tail;
  logic [CNT_WIDTH-1:0] free_cnt;

  logic push_in;
  logic pop_in;
  logic has_free;
  logic same;
  logic pop_one;
  logic push_to_empty;

  assign push_in  = int'(push_sel) < NUM_FIFOS;
  assign pop_in   = int'(pop_sel) < NUM_FIFOS;
  assign has_free = free_cnt != '0;
  assign same     = push_sel == pop_sel;

  assign pop_ok  = pop && pop_in && (cnt[pop_sel] != '0);
  assign push_ok = push && push_in && (has_free || pop_ok);

  assign free_ptr  = head[pop_sel];
  assign alloc_ptr = has_free ? free_head : free_ptr;

  // Same-FIFO pop of the last entry: the pushed entry becomes the new head.
  assign pop_one = pop_ok && same && (cnt[pop_sel] == CNT_WIDTH'(1));
  assign push_to_empty = (cnt[push_sel] == '0) || pop_one;

  always_comb begin
    count = '0;
    empty = '0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      count[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
      empty[i] = cnt[i] == '0;
    end
  end

  assign full       = !has_free;
  assign free_count = free_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        nxt[i] <= PTR_WIDTH'(free_init(i, DEPTH));
      for (int i = 0; i < NUM_FIFOS; i++) begin
        head[i] <= '0;
        tail[i] <= '0;
        cnt[i]  <= '0;
      end
      free_head <= '0;
      free_tail <= PTR_WIDTH'(DEPTH - 1);
      free_cnt  <= CNT_WIDTH'(DEPTH);
    end else begin
      if (pop_ok && !(push_ok && pop_one))
        head[pop_sel] <= nxt[free_ptr];

      if (push_ok) begin
        tail[push_sel] <= alloc_ptr;
        if (push_to_empty)
          head[push_sel] <= alloc_ptr;
        else
          nxt[tail[push_sel]] <= alloc_ptr;
      end

      // Free list: allocate from head, return popped entries at tail.
      case ({pop_ok, push_ok})
        2'b10: begin
          if (!has_free) begin
            free_head <= free_ptr;
            free_tail <= free_ptr;
          end else begin
            nxt[free_tail] <= free_ptr;
            free_tail      <= free_ptr;
          end
        end
        2'b01: free_head <= nxt[free_head];
        2'b11: begin
          if (free_cnt == CNT_WIDTH'(1)) begin
            free_head <= free_ptr;
            free_tail <= free_ptr;
          end else if (has_free) begin
            free_head      <= nxt[free_head];
            nxt[free_tail] <= free_ptr;
            free_tail      <= free_ptr;
          end
        end
        default: ;
      endcase

      for (int i = 0; i < NUM_FIFOS; i++) begin
        if (push_ok && push_sel == SEL_WIDTH'(i) &&
            !(pop_ok && pop_sel == SEL_WIDTH'(i)))
          cnt[i] <= cnt[i] + CNT_WIDTH'(1);
        else if (pop_ok && pop_sel == SEL_WIDTH'(i) &&
                 !(push_ok && push_sel == SEL_WIDTH'(i)))
          cnt[i] <= cnt[i] - CNT_WIDTH'(1);
      end

      if (pop_ok && !push_ok)
        free_cnt <= free_cnt + CNT_WIDTH'(1);
      else if (push_ok && !pop_ok)
        free_cnt <= free_cnt - CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/shared_multi_fifo.sv
// Shared-memory multi-FIFO top: data store, registered read port, error flags.
// Pointer and list management live in sml_ptr_ctrl.
module shared_multi_fifo
  import shared_multi_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int NUM_FIFOS = 4,
  parameter int PTR_WIDTH = ptr_w(DEPTH),
  parameter int SEL_WIDTH = sel_w(NUM_FIFOS),
  parameter int CNT_WIDTH = cnt_w(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [SEL_WIDTH-1:0]           push_sel,
  input  logic [WIDTH-1:0]               data_in,
  input  logic                           pop,
  input  logic [SEL_WIDTH-1:0]           pop_sel,
  output logic                           full,
  output logic [NUM_FIFOS-1:0]           empty,
  output logic [NUM_FIFOS*CNT_WIDTH-1:0] count,
  output logic [CNT_WIDTH-1:0]           free_count,
  output logic [WIDTH-1:0]               data_out,
  output logic                           out_valid,
  output logic                           err_overflow,
  output logic                           err_underflow
);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] alloc_ptr;
  logic [PTR_WIDTH-1:0] free_ptr;
  logic                 push_ok;
  logic                 pop_ok;
  logic [ERR_W-1:0]     err;

  sml_ptr_ctrl #(
    .DEPTH     (DEPTH),
    .NUM_FIFOS (NUM_FIFOS),
    .PTR_WIDTH (PTR_WIDTH),
    .SEL_WIDTH (SEL_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_sel   (push_sel),
    .pop        (pop),
    .pop_sel    (pop_sel),
    .alloc_ptr  (alloc_ptr),
    .free_ptr   (free_ptr),
    .push_ok    (push_ok),
    .pop_ok     (pop_ok),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .free_count (free_count)
  );

  // Contents survive reset; the lists decide what is live.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[alloc_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out  <= '0;
      out_valid <= 1'b0;
      err       <= '0;
    end else begin
      out_valid <= pop_ok;
      if (pop_ok)
        data_out <= mem[free_ptr];
      if (push && !push_ok)
        err[ERR_OVF] <= 1'b1;
      if (pop && !pop_ok)
        err[ERR_UNF] <= 1'b1;
    end
  end

  assign err_overflow  = err[ERR_OVF];
  assign err_underflow = err[ERR_UNF];

endmodule

// File: tb/tb_shared_multi_fifo.sv
// Directed bench for shared_multi_fifo: vector table plus corner sequences.
// Counts are packed {c3,c2,c1,c0}, one hex digit per FIFO.
module tb_shared_multi_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push = 1'b0;
  logic [1:0] push_sel = '0;
  logic [7:0] data_in = '0;
  logic       pop = 1'b0;
  logic [1:0] pop_sel = '0;
  logic       full;
  logic [3:0] empty;
  logic [15:0] count;
  logic [3:0] free_count;
  logic [7:0] data_out;
  logic       out_valid;
  logic       err_overflow;
  logic       err_underflow;

  int pass_cnt = 0;
  int total = 0;

  shared_multi_fifo dut (
    .clk           (clk),
    .rst           (rst),
    .push          (push),
    .push_sel      (push_sel),
    .data_in       (data_in),
    .pop           (pop),
    .pop_sel       (pop_sel),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .free_count    (free_count),
    .data_out      (data_out),
    .out_valid     (out_valid),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        push;
    logic [1:0]  ps;
    logic [7:0]  din;
    logic        pop;
    logic [1:0]  qs;
    logic [15:0] cnt;
    logic [3:0]  fc;
    logic        ov;
    logic [7:0]  dout;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic pu, input logic [1:0] ps, input logic [7:0] din,
    input logic po, input logic [1:0] qs, input logic [15:0] c,
    input logic [3:0] fc, input logic ov, input logic [7:0] dout,
    input logic ovf, input logic unf);
    vec_t v;
    v.push = pu; v.ps = ps; v.din = din;
    v.pop = po; v.qs = qs; v.cnt = c; v.fc = fc;
    v.ov = ov; v.dout = dout; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic chk(input string nm, input int id,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s step %0d: got %h want %h", nm, id, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic check_all(input int id, input logic [15:0] c,
                           input logic [3:0] fc, input logic ov,
                           input logic [7:0] dout, input logic ovf,
                           input logic unf);
    logic [3:0] e;
    for (int i = 0; i < 4; i++)
      e[i] = c[i*4 +: 4] == 4'd0;
    chk("count", id, 32'(count), 32'(c));
    chk("free_count", id, 32'(free_count), 32'(fc));
    chk("empty", id, 32'(empty), 32'(e));
    chk("full", id, 32'(full), 32'(fc == 4'd0));
    chk("out_valid", id, 32'(out_valid), 32'(ov));
    chk("data_out", id, 32'(data_out), 32'(dout));
    chk("err_overflow", id, 32'(err_overflow), 32'(ovf));
    chk("err_underflow", id, 32'(err_underflow), 32'(unf));
  endtask

  task automatic cyc(input logic pu, input logic [1:0] ps,
                     input logic [7:0] din, input logic po,
                     input logic [1:0] qs);
    push = pu; push_sel = ps; data_in = din;
    pop = po; pop_sel = qs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vq.push_back(mk(1, 2, 8'hA1, 0, 0, 16'h0100, 7, 0, 8'h00, 0, 0));
    vq.push_back(mk(1, 2, 8'hA2, 0, 0, 16'h0200, 6, 0, 8'h00, 0, 0));
    vq.push_back(mk(0, 0, 8'h00, 1, 2, 16'h0100, 7, 1, 8'hA1, 0, 0));
    vq.push_back(mk(0, 0, 8'h00, 1, 2, 16'h0000, 8, 1, 8'hA2, 0, 0));
    vq.push_back(mk(0, 0, 8'h00, 0, 0, 16'h0000, 8, 0, 8'hA2, 0, 0));
    for (int k = 1; k <= 6; k++)
      vq.push_back(mk(1, 0, 8'(k), 0, 0, 16'(k), 4'(8 - k), 0, 8'hA2, 0, 0));
    vq.push_back(mk(1, 1, 8'h31, 0, 0, 16'h0016, 1, 0, 8'hA2, 0, 0));
    vq.push_back(mk(1, 1, 8'h32, 0, 0, 16'h0026, 0, 0, 8'hA2, 0, 0));
    vq.push_back(mk(1, 3, 8'h77, 0, 0, 16'h0026, 0, 0, 8'hA2, 1, 0));
    vq.push_back(mk(1, 3, 8'h55, 1, 0, 16'h1025, 0, 1, 8'h01, 1, 0));
    vq.push_back(mk(0, 0, 8'h00, 1, 3, 16'h0025, 1, 1, 8'h55, 1, 0));
    vq.push_back(mk(0, 0, 8'h00, 1, 1, 16'h0015, 2, 1, 8'h31, 1, 0));
    vq.push_back(mk(1, 1, 8'h11, 1, 1, 16'h0015, 2, 1, 8'h32, 1, 0));
    vq.push_back(mk(0, 0, 8'h00, 1, 1, 16'h0005, 3, 1, 8'h11, 1, 0));
    for (int k = 2; k <= 6; k++)
      vq.push_back(mk(0, 0, 8'h00, 1, 0, 16'(6 - k), 4'(2 + k), 1,
                      8'(k), 1, 0));
    vq.push_back(mk(1, 0, 8'h99, 1, 0, 16'h0001, 7, 0, 8'h06, 1, 1));
    vq.push_back(mk(0, 0, 8'h00, 1, 0, 16'h0000, 8, 1, 8'h99, 1, 1));
    vq.push_back(mk(0, 0, 8'h00, 1, 1, 16'h0000, 8, 0, 8'h99, 1, 1));

    rst = 1'b0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check_all(0, 16'h0000, 8, 0, 8'h00, 0, 0);
    rst = 1'b1;

    foreach (vq[i]) begin
      cyc(vq[i].push, vq[i].ps, vq[i].din, vq[i].pop, vq[i].qs);
      check_all(i + 1, vq[i].cnt, vq[i].fc, vq[i].ov, vq[i].dout,
                vq[i].ovf, vq[i].unf);
    end

    // One FIFO owns the whole store, then reuses its head slot while full.
    for (int k = 0; k < 8; k++)
      cyc(1, 0, 8'(8'hB0 + k), 0, 0);
    check_all(100, 16'h0008, 0, 0, 8'h99, 1, 1);
    cyc(1, 0, 8'hB8, 1, 0);
    check_all(101, 16'h0008, 0, 1, 8'hB0, 1, 1);
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 0, 0, 1, 0);
      check_all(101 + k, 16'(8 - k), 4'(k), 1, 8'(8'hB0 + k), 1, 1);
    end

    // Reset with live contents, then confirm only new data comes out.
    for (int k = 0; k < 5; k++)
      cyc(1, 1, 8'(8'hC0 + k), 0, 0);
    check_all(120, 16'h0050, 3, 0, 8'hB8, 1, 1);
    rst = 1'b0;
    cyc(1, 2, 8'hEE, 1, 1);
    check_all(121, 16'h0000, 8, 0, 8'h00, 0, 0);
    rst = 1'b1;
    cyc(1, 2, 8'hD1, 0, 0);
    check_all(122, 16'h0100, 7, 0, 8'h00, 0, 0);
    cyc(0, 0, 0, 1, 2);
    check_all(123, 16'h0000, 8, 1, 8'hD1, 0, 0);
    cyc(0, 0, 0, 1, 1);
    check_all(124, 16'h0000, 8, 0, 8'hD1, 0, 1);

    cyc(0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
